// File: rtl/bi_pad_seq.sv
// -----------------------------------------------------------------------------
// bi_pad_seq : cycle-accurate control sequencer for one bidirectional 24T pad.
//
// Turns a host valid/ready transmit stream and a receive enable into the pad
// control pins. It guarantees a dead turnaround after driving, an IE settle
// delay before the first sample, and pull-up/pull-down that are never both on.
//
// Ports
//   CLK, RN            clock, asynchronous active-low reset
//   tx_valid/tx_data   host bit to drive; accepted when tx_valid && tx_ready
//   tx_ready           high in IDLE and in the last hold cycle of DRIVE
//   rx_en              request input sampling while idle
//   rx_valid/rx_data   one-cycle pulse with the synchronized pad value
//   pull_sel           00 none, 01 pull-down, 10 pull-up, 11 keeper
//   slew_fast/schmitt  registered through to pad_SL / pad_CS
//   busy               high in every state other than IDLE
//   pad_A..pad_SL      pad control outputs
//   pad_Y              asynchronous pad input, 2-flop synchronized
// -----------------------------------------------------------------------------
module bi_pad_seq #(
   parameter int HOLD_CYC   = 4,
   parameter int TURN_CYC   = 2,
   parameter int SETTLE_CYC = 3,
   parameter int SAMPLE_DIV = 8
) (
   input  logic       CLK,
   input  logic       RN,
   input  logic       tx_valid,
   input  logic       tx_data,
   output logic       tx_ready,
   input  logic       rx_en,
   output logic       rx_valid,
   output logic       rx_data,
   input  logic [1:0] pull_sel,
   input  logic       slew_fast,
   input  logic       schmitt,
   output logic       busy,
   output logic       pad_A,
   output logic       pad_OE,
   output logic       pad_IE,
   output logic       pad_PU,
   output logic       pad_PD,
   output logic       pad_CS,
   output logic       pad_SL,
   input  logic       pad_Y
);

   typedef enum logic [2:0] {
      S_IDLE, S_DRIVE, S_TURN, S_SETTLE, S_SAMPLE
   } state_e;

   localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
   localparam logic [7:0] TURN_LD   = 8'(TURN_CYC - 1);
   localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] DIV_LD    = 8'(SAMPLE_DIV - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       bit_q, bit_d;
   logic       kv_q, kv_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rx_data_q, rx_data_d;
   logic       pu_q, pu_d;
   logic       pd_q, pd_d;
   logic       cs_q, sl_q;
   logic       sync1_q, sync2_q;
   logic       init_q;
   logic       accept;

   // init_q holds tx_ready low while in reset and until the first edge after
   // release, even though the state register already reads IDLE.
   assign tx_ready = init_q && ((state_q == S_IDLE) ||
                                ((state_q == S_DRIVE) && (cnt_q == 8'd0)));
   assign accept   = tx_valid && tx_ready;

   // Pad pins decode straight from the state register, so an asynchronous
   // reset pulls OE low at once rather than on the next edge.
   assign pad_OE   = (state_q == S_DRIVE);
   assign pad_A    = (state_q == S_DRIVE) && bit_q;
   assign pad_IE   = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
   assign busy     = (state_q != S_IDLE);
   assign pad_PU   = pu_q;
   assign pad_PD   = pd_q;
   assign pad_CS   = cs_q;
   assign pad_SL   = sl_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      kv_d       = kv_q;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_DRIVE;
               bit_d   = tx_data;
               cnt_d   = HOLD_LD;
            end else if (rx_en && init_q) begin
               state_d = S_SETTLE;
               cnt_d   = SETTLE_LD;
            end
         end
         S_DRIVE: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (accept) begin
               // Back-to-back bit: restart the hold with no OE gap.
               bit_d = tx_data;
               cnt_d = HOLD_LD;
            end else begin
               kv_d = bit_q;
               if (TURN_CYC == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_TURN;
                  cnt_d   = TURN_LD;
               end
            end
         end
         S_TURN: begin
            if (cnt_q == 8'd0) state_d = S_IDLE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         S_SETTLE: begin
            if (!rx_en) begin
               state_d = S_IDLE;
            end else if (cnt_q == 8'd0) begin
               state_d = S_SAMPLE;
               cnt_d   = DIV_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_SAMPLE: begin
            // A pending tx only leaves SAMPLE; it is accepted later from IDLE.
            if (!rx_en || tx_valid) begin
               state_d = S_IDLE;
            end else if (cnt_q == 8'd0) begin
               rx_valid_d = 1'b1;
               rx_data_d  = sync2_q;
               kv_d       = sync2_q;
               cnt_d      = DIV_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pulls decode once from the next state, then register: each branch sets
   // at most one of PU/PD, so the pair can never both be high.
   always_comb begin
      pu_d = 1'b0;
      pd_d = 1'b0;
      if (state_d != S_DRIVE) begin
         unique case (pull_sel)
            2'b01:   pd_d = 1'b1;
            2'b10:   pu_d = 1'b1;
            2'b11: begin
               pu_d = kv_d;
               pd_d = ~kv_d;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         bit_q      <= 1'b0;
         kv_q       <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 1'b0;
         pu_q       <= 1'b0;
         pd_q       <= 1'b0;
         cs_q       <= 1'b0;
         sl_q       <= 1'b0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         init_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the old
         // values, so the synchronizer chain really is two stages deep.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         kv_q       <= kv_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         pu_q       <= pu_d;
         pd_q       <= pd_d;
         cs_q       <= schmitt;
         sl_q       <= slew_fast;
         sync1_q    <= pad_Y;
         sync2_q    <= sync1_q;
         init_q     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bi_pad_seq.sv
// -----------------------------------------------------------------------------
// tb_bi_pad_seq : directed self-checking bench for bi_pad_seq with default
// parameters (HOLD=4, TURN=2, SETTLE=3, SAMPLE_DIV=8). Each task drives one
// scenario and compares outputs against hand-computed values 1 time unit
// after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_bi_pad_seq;

   logic       CLK = 1'b0;
   logic       RN;
   logic       tx_valid, tx_data, tx_ready;
   logic       rx_en, rx_valid, rx_data;
   logic [1:0] pull_sel;
   logic       slew_fast, schmitt, busy;
   logic       pad_A, pad_OE, pad_IE, pad_PU, pad_PD, pad_CS, pad_SL, pad_Y;

   int checks = 0;
   int errors = 0;

   bi_pad_seq #(.HOLD_CYC(4), .TURN_CYC(2), .SETTLE_CYC(3), .SAMPLE_DIV(8)) dut (
      .CLK(CLK), .RN(RN),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_en(rx_en), .rx_valid(rx_valid), .rx_data(rx_data),
      .pull_sel(pull_sel), .slew_fast(slew_fast), .schmitt(schmitt),
      .busy(busy),
      .pad_A(pad_A), .pad_OE(pad_OE), .pad_IE(pad_IE),
      .pad_PU(pad_PU), .pad_PD(pad_PD), .pad_CS(pad_CS), .pad_SL(pad_SL),
      .pad_Y(pad_Y)
   );

   always #5 CLK = ~CLK;

   // One clock, then settle 1 time unit past the edge before looking.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RN = 1'b0; tx_valid = 0; tx_data = 0; rx_en = 0; pull_sel = 2'b00;
      slew_fast = 0; schmitt = 0; pad_Y = 0;
      #2;
      checks++; if (pad_OE !== 1'b0) begin errors++; $display("FAIL rst_oe got %b want 0", pad_OE); end
      checks++; if (pad_IE !== 1'b0) begin errors++; $display("FAIL rst_ie got %b want 0", pad_IE); end
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_tx_ready got %b want 0", tx_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if ({pad_A, pad_PU, pad_PD, pad_CS, pad_SL, rx_valid, rx_data} !== 7'b0)
         begin errors++; $display("FAIL rst_misc got %b want 0000000",
                                  {pad_A, pad_PU, pad_PD, pad_CS, pad_SL, rx_valid, rx_data}); end
      @(negedge CLK); @(negedge CLK);
      RN = 1'b1;
      tick();
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", tx_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy got %b want 0", busy); end
   endtask

   task automatic test_passthru();
      schmitt = 1'b1;
      #1;
      checks++; if (pad_CS !== 1'b0) begin errors++; $display("FAIL cs_latency got %b want 0", pad_CS); end
      tick();
      checks++; if (pad_CS !== 1'b1) begin errors++; $display("FAIL cs_copy got %b want 1", pad_CS); end
      slew_fast = 1'b1;
      tick();
      checks++; if (pad_SL !== 1'b1) begin errors++; $display("FAIL sl_copy got %b want 1", pad_SL); end
      schmitt = 1'b0; slew_fast = 1'b0;
      tick();
      checks++; if ({pad_CS, pad_SL} !== 2'b00) begin errors++; $display("FAIL cs_sl_clear got %b want 00", {pad_CS, pad_SL}); end
   endtask

   task automatic test_single_bit();
      logic e_oe, e_busy, e_rdy;
      tx_valid = 1'b1; tx_data = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 1) tx_valid = 1'b0;
         e_oe   = (k <= 4);
         e_busy = (k <= 6);
         e_rdy  = (k == 4) || (k == 7);
         checks++; if (pad_OE !== e_oe) begin errors++; $display("FAIL single_oe cyc %0d got %b want %b", k, pad_OE, e_oe); end
         checks++; if (pad_A !== e_oe) begin errors++; $display("FAIL single_a cyc %0d got %b want %b", k, pad_A, e_oe); end
         checks++; if (pad_IE !== 1'b0) begin errors++; $display("FAIL single_ie cyc %0d got %b want 0", k, pad_IE); end
         checks++; if (busy !== e_busy) begin errors++; $display("FAIL single_busy cyc %0d got %b want %b", k, busy, e_busy); end
         checks++; if (tx_ready !== e_rdy) begin errors++; $display("FAIL single_ready cyc %0d got %b want %b", k, tx_ready, e_rdy); end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] bits;
      logic       e_a;
      bits = 3'b101;   // bits[2] first, then bits[1], bits[0]
      tx_valid = 1'b1; tx_data = bits[2];
      for (int k = 1; k <= 13; k++) begin
         tick();
         if (k == 4) tx_data = bits[1];
         if (k == 8) tx_data = bits[0];
         if (k == 9) tx_valid = 1'b0;
         if (k <= 12) begin
            e_a = bits[2 - (k - 1) / 4];
            checks++; if (pad_OE !== 1'b1) begin errors++; $display("FAIL b2b_oe cyc %0d got %b want 1", k, pad_OE); end
            checks++; if (pad_A !== e_a) begin errors++; $display("FAIL b2b_a cyc %0d got %b want %b", k, pad_A, e_a); end
         end else begin
            checks++; if (pad_OE !== 1'b0) begin errors++; $display("FAIL b2b_oe_end got %b want 0", pad_OE); end
         end
         if (k <= 11) begin
            checks++; if (tx_ready !== ((k == 4) || (k == 8)))
               begin errors++; $display("FAIL b2b_ready cyc %0d got %b want %b", k, tx_ready, (k == 4) || (k == 8)); end
         end
      end
      tick(); tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy got %b want 0", busy); end
   endtask

   task automatic test_rx_sample();
      int n;
      pad_Y = 1'b1;
      tick(); tick(); tick();
      rx_en = 1'b1;
      tick();
      checks++; if (pad_IE !== 1'b1) begin errors++; $display("FAIL rx_ie_rise got %b want 1", pad_IE); end
      checks++; if (pad_OE !== 1'b0) begin errors++; $display("FAIL rx_oe got %b want 0", pad_OE); end
      n = 0;
      while (rx_valid !== 1'b1 && n < 30) begin tick(); n++; end
      checks++; if (n !== 11) begin errors++; $display("FAIL rx_first_latency got %0d want 11", n); end
      checks++; if (rx_data !== 1'b1) begin errors++; $display("FAIL rx_first_data got %b want 1", rx_data); end
      pad_Y = 1'b0;
      tick();
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_pulse_width got %b want 0", rx_valid); end
      n = 1;
      while (rx_valid !== 1'b1 && n < 30) begin tick(); n++; end
      checks++; if (n !== 8) begin errors++; $display("FAIL rx_second_latency got %0d want 8", n); end
      checks++; if (rx_data !== 1'b0) begin errors++; $display("FAIL rx_second_data got %b want 0", rx_data); end
      rx_en = 1'b0;
      tick();
      checks++; if ({pad_IE, busy} !== 2'b00) begin errors++; $display("FAIL rx_exit ie_busy got %b want 00", {pad_IE, busy}); end
   endtask

   task automatic test_keeper();
      int n;
      pull_sel = 2'b11;
      for (int b = 0; b < 2; b++) begin
         tx_valid = 1'b1; tx_data = b[0];
         tick();
         tx_valid = 1'b0;
         checks++; if ({pad_PU, pad_PD} !== 2'b00) begin errors++; $display("FAIL keep_drive_pulls bit %0d got %b want 00", b, {pad_PU, pad_PD}); end
         tick(); tick(); tick(); tick();   // first TURN cycle
         checks++; if ({pad_PU, pad_PD} !== {b[0], ~b[0]})
            begin errors++; $display("FAIL keep_turn bit %0d got %b want %b", b, {pad_PU, pad_PD}, {b[0], ~b[0]}); end
         tick(); tick();                   // IDLE
         checks++; if ({pad_PU, pad_PD} !== {b[0], ~b[0]})
            begin errors++; $display("FAIL keep_idle bit %0d got %b want %b", b, {pad_PU, pad_PD}, {b[0], ~b[0]}); end
      end
      pull_sel = 2'b01;
      tick();
      checks++; if ({pad_PU, pad_PD} !== 2'b01) begin errors++; $display("FAIL pull_down got %b want 01", {pad_PU, pad_PD}); end
      pull_sel = 2'b10;
      tick();
      checks++; if ({pad_PU, pad_PD} !== 2'b10) begin errors++; $display("FAIL pull_up got %b want 10", {pad_PU, pad_PD}); end
      pull_sel = 2'b00;
      tick();
      checks++; if ({pad_PU, pad_PD} !== 2'b00) begin errors++; $display("FAIL pull_none got %b want 00", {pad_PU, pad_PD}); end
      for (int k = 0; k < 80; k++) begin
         pull_sel = 2'($urandom_range(0, 3));
         tx_valid = ($urandom_range(0, 3) == 0);
         tx_data  = 1'($urandom_range(0, 1));
         tick();
         checks++; if ((pad_PU && pad_PD) !== 1'b0) begin errors++; $display("FAIL pull_exclusive cyc %0d pu %b pd %b", k, pad_PU, pad_PD); end
         checks++; if ((pad_OE && pad_IE) !== 1'b0) begin errors++; $display("FAIL oe_ie_exclusive cyc %0d oe %b ie %b", k, pad_OE, pad_IE); end
      end
      tx_valid = 1'b0; pull_sel = 2'b00;
      n = 0;
      while (busy !== 1'b0 && n < 20) begin tick(); n++; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL keep_drain busy got %b want 0", busy); end
   endtask

   task automatic test_conflict();
      int n;
      tx_valid = 1'b1; tx_data = 1'b1; rx_en = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) begin
            tx_valid = 1'b0;
            checks++; if (pad_OE !== 1'b1) begin errors++; $display("FAIL conflict_oe got %b want 1", pad_OE); end
         end
         checks++; if (pad_IE !== 1'b0) begin errors++; $display("FAIL conflict_ie cyc %0d got %b want 0", k, pad_IE); end
      end
      tick(); tick();                      // IDLE, then SETTLE
      checks++; if (pad_IE !== 1'b1) begin errors++; $display("FAIL conflict_settle_ie got %b want 1", pad_IE); end
      tick(); tick(); tick();              // now in SAMPLE
      checks++; if ({pad_IE, pad_OE, tx_ready} !== 3'b100)
         begin errors++; $display("FAIL sample_state got %b want 100", {pad_IE, pad_OE, tx_ready}); end
      tx_valid = 1'b1; tx_data = 1'b0;
      tick();
      checks++; if ({pad_IE, pad_OE} !== 2'b00) begin errors++; $display("FAIL sample_exit ie_oe got %b want 00", {pad_IE, pad_OE}); end
      tick();
      checks++; if ({pad_IE, pad_OE} !== 2'b01) begin errors++; $display("FAIL sample_to_drive ie_oe got %b want 01", {pad_IE, pad_OE}); end
      tx_valid = 1'b0; rx_en = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 20) begin tick(); n++; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL conflict_drain busy got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_drive();
      schmitt = 1'b1; slew_fast = 1'b1;
      tx_valid = 1'b1; tx_data = 1'b1;
      tick();                              // DRIVE cycle 1
      tx_valid = 1'b0;
      tick();                              // DRIVE cycle 2
      checks++; if (pad_OE !== 1'b1) begin errors++; $display("FAIL mid_pre_oe got %b want 1", pad_OE); end
      #2 RN = 1'b0;
      #1;
      checks++; if (pad_OE !== 1'b0) begin errors++; $display("FAIL mid_async_oe got %b want 0", pad_OE); end
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b want 0", tx_ready); end
      checks++; if ({busy, pad_A, pad_IE, pad_PU, pad_PD, pad_CS, pad_SL, rx_valid, rx_data} !== 9'b0)
         begin errors++; $display("FAIL mid_outputs got %b want 000000000",
                                  {busy, pad_A, pad_IE, pad_PU, pad_PD, pad_CS, pad_SL, rx_valid, rx_data}); end
      schmitt = 1'b0; slew_fast = 1'b0;
      @(negedge CLK); @(negedge CLK);
      RN = 1'b1;
      tick();
      checks++; if ({tx_ready, busy, pad_OE} !== 3'b100)
         begin errors++; $display("FAIL mid_release ready_busy_oe got %b want 100", {tx_ready, busy, pad_OE}); end
      tick();
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rx got %b want 0", rx_valid); end
   endtask

   initial begin
      test_reset();
      test_passthru();
      test_single_bit();
      test_back_to_back();
      test_rx_sample();
      test_keeper();
      test_conflict();
      test_reset_mid_drive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
